// File: rtl/mod14_counter.sv
// Synchronous modulo-14 up/down counter with parallel load and synchronous reset.
// Optional terminal-count output `tc` is built when MOD14_TC_EN is defined.
module mod14_counter #(
    parameter int MODULUS = 14,
    parameter int WIDTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] count_in,
    output logic [WIDTH-1:0] count_out
`ifdef MOD14_TC_EN
    ,
    output logic             tc
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] load_val_s;
    logic [WIDTH-1:0] step_s;

    // Out-of-range register contents (only possible before reset) recover to 0.
    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                    input logic              up);
        logic [WIDTH-1:0] nxt;
        nxt = ZERO;
        if (cur > MAX_VAL) begin
            nxt = ZERO;
        end else begin
            case (up)
                1'b1:    nxt = (cur == MAX_VAL) ? ZERO : cur + ONE;
                1'b0:    nxt = (cur == ZERO) ? MAX_VAL : cur - ONE;
                default: nxt = ZERO;
            endcase
        end
        return nxt;
    endfunction

    // Preset value, clamped to 0 when count_in is outside the count range.
    always_comb begin
        load_val_s = ZERO;
        if (count_in > MAX_VAL) begin
            load_val_s = ZERO;
        end else begin
            load_val_s = count_in;
        end
    end

    // Next value when neither reset nor load is active.
    always_comb begin
        step_s = next_count(count_r, mode);
    end

    // Counter register: reset beats load, load beats counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= ZERO;
        end else if (load) begin
            count_r <= load_val_s;
        end else begin
            count_r <= step_s;
        end
    end

    assign count_out = count_r;

`ifdef MOD14_TC_EN
    // Terminal count flags the wrap point for the current direction.
    always_comb begin
        tc = 1'b0;
        if (mode) begin
            tc = (count_r == MAX_VAL);
        end else begin
            tc = (count_r == ZERO);
        end
    end
`endif

endmodule

// File: tb/tb_mod14_counter.sv
// Directed self-checking bench for mod14_counter; checks tc too when MOD14_TC_EN is defined.
module tb_mod14_counter;

    logic       clock;
    logic       reset;
    logic       load;
    logic       mode;
    logic [3:0] count_in;
    logic [3:0] count_out;
`ifdef MOD14_TC_EN
    logic       tc;
`endif

    int checks_r;
    int errors_r;

    mod14_counter #(.MODULUS(14), .WIDTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .mode      (mode),
        .count_in  (count_in),
        .count_out (count_out)
`ifdef MOD14_TC_EN
        ,
        .tc        (tc)
`endif
    );

    // 10-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check count_out (and tc) 1 unit after the edge.
    task automatic step_check(input string tag, input int exp_count);
        @(posedge clock);
        #1;
        check_value(tag, {28'd0, count_out}, exp_count[31:0]);
`ifdef MOD14_TC_EN
        check_value({tag, "_tc"}, {31'd0, tc},
                    (mode ? (exp_count == 13) : (exp_count == 0)) ? 32'd1 : 32'd0);
`endif
    endtask

    initial begin
        checks_r = 0;
        errors_r = 0;
        reset    = 1'b1;
        load     = 1'b0;
        mode     = 1'b1;
        count_in = 4'd0;

        step_check("reset_0", 0);
        step_check("reset_1", 0);

        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step_check("count_up", k % 14);
        end

        load = 1'b1; count_in = 4'd2;
        step_check("load_2", 2);
        load = 1'b0; mode = 1'b0;
        step_check("down_1", 1);
        step_check("down_0", 0);
        step_check("down_wrap_13", 13);
        step_check("down_12", 12);

        load = 1'b1; count_in = 4'd9;
        step_check("load_9", 9);
        count_in = 4'd14;
        step_check("load_14", 0);
        count_in = 4'd15;
        step_check("load_15", 0);

        reset = 1'b1; load = 1'b1; count_in = 4'd5;
        step_check("prio_reset", 0);
        reset = 1'b0;
        step_check("prio_load", 5);
        load = 1'b0; mode = 1'b1;
        step_check("prio_count", 6);

        load = 1'b1; count_in = 4'd12; mode = 1'b0;
        step_check("load_12_mode_ignored", 12);
        load = 1'b0; mode = 1'b1;
        step_check("dir_up_13", 13);
        mode = 1'b0;
        step_check("dir_down_12", 12);
        step_check("dir_down_11", 11);

        reset = 1'b1;
        step_check("reset_mid", 0);
        reset = 1'b0; mode = 1'b1;
        step_check("resume_1", 1);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
